bcd_scan_display: RTL and testbench
===================================

# bcd_scan_display

Multiplexed seven-segment display driver that consumes the BCD digits produced by a chain of cascaded decade counters. It captures `NDIG` packed BCD nibbles into a snapshot register on `load`. It then time-multiplexes them onto one shared active-low segment bus, with per-digit active-low anode enables. It is the final stage between the counter chain and the board display pins.

## Interface
- `NDIG`, 4, number of BCD digits scanned (≥ 1)
- `PRESCALE`, 50000, clk cycles per digit slot (≥ 2)

Ports:
- `clk` in 1: system clock, rising edge
- `rst` in 1: asynchronous, active-low reset; clock `clk`
- `bcd_in` in 4*NDIG: packed BCD; nibble i = `bcd_in[4i+3:4i]`, nibble 0 = least significant
- `load` in 1: capture `bcd_in` into snapshot on this clk edge
- `seg` out 7: active-low segments, bit0=a … bit6=g
- `an` out NDIG: active-low digit enables, `an[i]` drives digit i
- `frame_done` out 1: one-cycle pulse at end of each full scan frame

## Operation
- Snapshot register `snap` (4*NDIG bits):
  - loads `bcd_in` on any edge with `load`=1;
  - holds otherwise;
  - a load mid-slot is legal and takes effect immediately.
- Prescaler `cnt` counts 0..PRESCALE-1 and wraps to 0.
- Digit index `idx` counts 0..NDIG-1 and increments when `cnt`=PRESCALE-1; it wraps from NDIG-1 to 0.
- Slot decode (combinational, from `cnt`, `idx`, `snap`):
  - `cnt`=0 is the blanking cycle: all anodes off, `seg`=7'h7F (ghosting guard).
  - Otherwise anode `idx` is on (others off), and `seg` is the decode of nibble `idx`.
- Decoder values (active low):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Any nibble A–F shows a dash, 7'h3F.
- `frame_done` is the registered version of (`cnt`=PRESCALE-1 && `idx`=NDIG-1).

## Timing
- `seg`, `an` and `frame_done` are registered from the slot decode, so they lag the internal state by 1 cycle.
- Latency from `load` edge to the new value on `seg`: 1 cycle, provided the affected digit is currently displayed and not blanked.
- Per digit slot: 1 blank cycle followed by PRESCALE-1 lit cycles.
- Frame period is NDIG*PRESCALE cycles; `frame_done` is high for exactly 1 cycle per frame.
- Reset value of every output: `an`=all ones, `seg`=7'h7F, `frame_done`=0. Internal state on reset: `snap`=0, `cnt`=0, `idx`=0.
- Reset is asynchronous: outputs reach their reset values immediately on `rst` falling, including mid-slot.
- Sequence after `rst` release:
  - first edge: `cnt` 0→1, outputs show blank;
  - second edge: `an[0]`=0 with digit 0 lit.
- `load` coinciding with a slot change: the new digit is decoded from the new snapshot (no stale nibble).

## Configuration
- `BCD_LZB_EN` defined: leading-zero blanking.
  - A digit i>0 is blanked (anode held off, `seg`=7'h7F for the whole slot) when nibble i and all higher nibbles are 0.
  - Digit 0 is never blanked.
  - Invalid nibbles (A–F) count as non-zero.
- `BCD_LZB_EN` undefined: all digits are lit, and leading zeros show 7'h40.
- Slot timing and `frame_done` are identical in both builds.

## Structure
- Shared package `bcd_disp_pkg` holds:
  - segment pattern constants `SEG_0`..`SEG_9`, `SEG_DASH`=7'h3F, `SEG_OFF`=7'h7F;
  - a 4-bit BCD digit typedef.
- One sub-module, `bcd_to_seg`: combinational nibble→active-low pattern decoder, instantiated once on the selected nibble.
- Prescaler, index, snapshot, blanking logic and output registers live in the top module.

## Test plan
All scenarios use NDIG=4, PRESCALE=4.
- Reset: hold `rst`=0 → `an`=4'b1111, `seg`=7'h7F, `frame_done`=0. Release `rst` → `an[0]`=0 at the second edge.
- Load 16'h1234:
  - digit slots show 4→7'h19, 3→7'h30, 2→7'h24, 1→7'h79 on `an` 1110, 1101, 1011, 0111 respectively;
  - each lit for 3 cycles after 1 blank cycle.
- Load 16'h0007 with `BCD_LZB_EN`: digit 0 shows 7'h78, and `an` stays 1111 during slots 1–3. Without the macro, slots 1–3 show 7'h40. Load 16'h0000 with the macro: digit 0 shows 7'h40.
- Load 16'h00A0: digit 1 shows 7'h3F and digit 0 shows 7'h40. Under `BCD_LZB_EN`, digit 1 is lit and not blanked.
- Free run: `frame_done` pulses for 1 cycle every 16 cycles. Load 16'h9999 mid-slot on digit 2 → `seg`=7'h10 one cycle later.
- Assert `rst` asynchronously mid-slot on digit 2 → `an`=1111 immediately. After release, the scan restarts at digit 0 with `snap`=0 (shows 7'h40).

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared types and active-low seven-segment patterns for the BCD scan display.
// Bit order of every pattern: bit0 = a ... bit6 = g.
package bcd_disp_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  typedef logic [BCD_W-1:0] bcd_digit_t;
  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_0    = 7'h40;
  localparam seg_t SEG_1    = 7'h79;
  localparam seg_t SEG_2    = 7'h24;
  localparam seg_t SEG_3    = 7'h30;
  localparam seg_t SEG_4    = 7'h19;
  localparam seg_t SEG_5    = 7'h12;
  localparam seg_t SEG_6    = 7'h02;
  localparam seg_t SEG_7    = 7'h78;
  localparam seg_t SEG_8    = 7'h00;
  localparam seg_t SEG_9    = 7'h10;
  localparam seg_t SEG_DASH = 7'h3F;
  localparam seg_t SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Non-decimal nibbles (A-F) render as a dash.
module bcd_to_seg
  import bcd_disp_pkg::*;
(
  input  bcd_digit_t digit,
  output seg_t       seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (digit)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Multiplexed seven-segment driver: snapshots NDIG BCD digits and scans them
// onto a shared active-low segment bus. Define BCD_LZB_EN for leading-zero blanking.
module bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int unsigned NDIG     = 4,
  parameter int unsigned PRESCALE = 50000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BCD_W*NDIG-1:0]  bcd_in,
  input  logic                   load,
  output seg_t                   seg,
  output logic [NDIG-1:0]        an,
  output logic                   frame_done
);

  localparam int unsigned SNAP_W = BCD_W * NDIG;
  localparam int unsigned CNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NDIG - 1);

  logic [SNAP_W-1:0] snap, snap_nxt;
  logic [CNT_W-1:0]  cnt,  cnt_nxt;
  logic [IDX_W-1:0]  idx,  idx_nxt;

  bcd_digit_t        sel_nib;
  logic [NDIG-1:0]   an_sel;
  seg_t              dec_seg;
  logic              lz_blank;

  seg_t              seg_nxt;
  logic [NDIG-1:0]   an_nxt;
  logic              frame_done_nxt;

  // Scan state and snapshot registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap <= '0;
      cnt  <= '0;
      idx  <= '0;
    end else begin
      snap <= snap_nxt;
      cnt  <= cnt_nxt;
      idx  <= idx_nxt;
    end
  end

  // Prescaler wrap advances the digit index
  always_comb begin
    snap_nxt = snap;
    cnt_nxt  = cnt + CNT_W'(1);
    idx_nxt  = idx;
    if (load) begin
      snap_nxt = bcd_in;
    end
    if (cnt == CNT_MAX) begin
      cnt_nxt = '0;
      idx_nxt = (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
    end
  end

  // Select the nibble and anode for the current digit
  always_comb begin
    sel_nib = '0;
    an_sel  = '1;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (idx == IDX_W'(i)) begin
        sel_nib   = snap[BCD_W*i +: BCD_W];
        an_sel[i] = 1'b0;
      end
    end
  end

`ifdef BCD_LZB_EN
  // Digit i>0 is blanked when it and every higher nibble are zero
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_blank = 1'b0;
    for (int i = int'(NDIG) - 1; i >= 1; i--) begin
      all_zero = all_zero && (snap[BCD_W*i +: BCD_W] == 4'h0);
      if (idx == IDX_W'(i)) begin
        lz_blank = all_zero;
      end
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  bcd_to_seg u_dec (
    .digit (sel_nib),
    .seg_c (dec_seg)
  );

  // Slot decode: first cycle of each slot is blank to avoid ghosting
  always_comb begin
    seg_nxt        = SEG_OFF;
    an_nxt         = '1;
    frame_done_nxt = (cnt == CNT_MAX) && (idx == IDX_MAX);
    if ((cnt != '0) && !lz_blank) begin
      seg_nxt = dec_seg;
      an_nxt  = an_sel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg        <= SEG_OFF;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_nxt;
      an         <= an_nxt;
      frame_done <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized self-checking bench for bcd_scan_display (NDIG=4, PRESCALE=4),
// compared against a cycle-count based reference model.
module tb_bcd_scan_display;

  localparam int unsigned NDIG     = 4;
  localparam int unsigned PRESCALE = 4;
`ifdef BCD_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] bcd_in = '0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int vectors = 0;
  int errors  = 0;

  // Model state: edges since reset release and the snapshot value
  int unsigned m_t    = 0;
  logic [15:0] m_snap = '0;
  logic [6:0]  e_seg;
  logic [3:0]  e_an;
  logic        e_fd;

  bcd_scan_display #(.NDIG(NDIG), .PRESCALE(PRESCALE)) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .load       (load),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input int unsigned v);
    case (v)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Apply inputs for one edge; produce the outputs expected just after it
  task automatic advance(input logic ld, input logic [15:0] val);
    int unsigned c, d;
    load   = ld;
    bcd_in = val;
    @(posedge clk);
    #1;
    c    = m_t % PRESCALE;
    d    = (m_t / PRESCALE) % NDIG;
    e_fd = (c == PRESCALE - 1) && (d == NDIG - 1);
    if (c == 0 || (LZB && d != 0 && (m_snap >> (4 * d)) == 16'h0)) begin
      e_an  = 4'b1111;
      e_seg = 7'h7F;
    end else begin
      e_an  = ~(4'b0001 << d);
      e_seg = ref_seg(int'((m_snap >> (4 * d)) & 16'hF));
    end
    m_t++;
    if (ld) m_snap = val;
    load = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst    = 1'b1;
    m_t    = 0;
    m_snap = '0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({an, seg, frame_done} !== {4'b1111, 7'h7F, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: an=%b seg=%h fd=%b, want an=1111 seg=7f fd=0", an, seg, frame_done);
    end
    release_reset();
    advance(1'b0, 16'h0);
    vectors++;
    if (an !== 4'b1111 || seg !== 7'h7F) begin
      errors++;
      $display("FAIL reset_first_edge: an=%b seg=%h, want an=1111 seg=7f", an, seg);
    end
    advance(1'b0, 16'h0);
    vectors++;
    if (an !== 4'b1110 || seg !== 7'h40) begin
      errors++;
      $display("FAIL reset_second_edge: an=%b seg=%h, want an=1110 seg=40", an, seg);
    end
  endtask

  task automatic test_load_pattern(input string name, input logic [15:0] val);
    int lit [4];
    for (int i = 0; i < 4; i++) lit[i] = 0;
    advance(1'b1, val);
    for (int k = 0; k < 2 * NDIG * PRESCALE; k++) begin
      advance(1'b0, 16'h0);
      vectors++;
      if ({seg, an, frame_done} !== {e_seg, e_an, e_fd}) begin
        errors++;
        $display("FAIL %s cyc%0d: seg=%h an=%b fd=%b, want seg=%h an=%b fd=%b",
                 name, k, seg, an, frame_done, e_seg, e_an, e_fd);
      end
      if (k >= int'(NDIG * PRESCALE)) begin
        for (int i = 0; i < 4; i++) if (an[i] === 1'b0) lit[i]++;
      end
    end
    if (val == 16'h1234) begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (lit[i] != int'(PRESCALE - 1)) begin
          errors++;
          $display("FAIL %s lit_count d%0d: %0d cycles, want %0d", name, i, lit[i], PRESCALE - 1);
        end
      end
    end
  endtask

  task automatic test_frame_done();
    int pulses = 0;
    int last = -1;
    for (int k = 0; k < 2 * NDIG * PRESCALE; k++) begin
      advance(1'b0, 16'h0);
      vectors++;
      if ({seg, an, frame_done} !== {e_seg, e_an, e_fd}) begin
        errors++;
        $display("FAIL frame_run cyc%0d: seg=%h an=%b fd=%b, want seg=%h an=%b fd=%b",
                 k, seg, an, frame_done, e_seg, e_an, e_fd);
      end
      if (frame_done === 1'b1) begin
        if (last >= 0) begin
          vectors++;
          if (k - last != int'(NDIG * PRESCALE)) begin
            errors++;
            $display("FAIL frame_period: %0d cycles, want %0d", k - last, NDIG * PRESCALE);
          end
        end
        last = k;
        pulses++;
      end
    end
    vectors++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL frame_pulses: %0d pulses in 32 cycles, want 2", pulses);
    end
  endtask

  task automatic test_midslot_load();
    int guard = 0;
    while (!((m_t % PRESCALE) == 1 && ((m_t / PRESCALE) % NDIG) == 2) && guard < 64) begin
      advance(1'b0, 16'h0);
      guard++;
    end
    vectors++;
    if (guard >= 64) begin
      errors++;
      $display("FAIL midslot_align: slot 2 not reached, got %0d want <64", guard);
    end
    advance(1'b1, 16'h9999);
    advance(1'b0, 16'h0);
    vectors++;
    if (seg !== 7'h10 || an !== 4'b1011 || seg !== e_seg) begin
      errors++;
      $display("FAIL midslot_load: seg=%h an=%b, want seg=10 an=1011 (model %h)", seg, an, e_seg);
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    logic        ld;
    for (int k = 0; k < 300; k++) begin
      ld = ($urandom_range(0, 3) == 0);
      v  = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 3)));
      advance(ld, v);
      vectors++;
      if ({seg, an, frame_done} !== {e_seg, e_an, e_fd}) begin
        errors++;
        $display("FAIL random cyc%0d: seg=%h an=%b fd=%b, want seg=%h an=%b fd=%b",
                 k, seg, an, frame_done, e_seg, e_an, e_fd);
      end
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    advance(1'b1, 16'h5678);
    while (!((m_t % PRESCALE) == 2 && ((m_t / PRESCALE) % NDIG) == 2) && guard < 64) begin
      advance(1'b0, 16'h0);
      guard++;
    end
    advance(1'b0, 16'h0);
    vectors++;
    if (an !== 4'b1011) begin
      errors++;
      $display("FAIL async_pre: an=%b, want 1011", an);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({an, seg, frame_done} !== {4'b1111, 7'h7F, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: an=%b seg=%h fd=%b, want an=1111 seg=7f fd=0", an, seg, frame_done);
    end
    repeat (2) @(posedge clk);
    release_reset();
    advance(1'b0, 16'h0);
    advance(1'b0, 16'h0);
    vectors++;
    if (an !== 4'b1110 || seg !== 7'h40) begin
      errors++;
      $display("FAIL async_restart: an=%b seg=%h, want an=1110 seg=40", an, seg);
    end
  endtask

  initial begin
    test_reset();
    test_load_pattern("load_1234", 16'h1234);
    test_load_pattern("load_0007", 16'h0007);
    test_load_pattern("load_0000", 16'h0000);
    test_load_pattern("load_00A0", 16'h00A0);
    test_frame_done();
    test_midslot_load();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
